// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and select codes for the forwarding / load-use hazard unit.
// Pipeline-stage tracking slots and the producer test live here.
package fwd_pkg;

    localparam int SLOT_ADDR_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB1   = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] rd;
        logic                   regwrite;
        logic                   memread;
    } stage_slot_t;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    function automatic logic is_producer(input logic valid, input logic regwrite,
                                         input logic [SLOT_ADDR_W-1:0] rd,
                                         input logic [SLOT_ADDR_W-1:0] src);
        return valid && regwrite && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side request bundle and EX-side forwarding results, plus debug view of the stage slots.
// Handshake: no valid/ready; id_valid qualifies the ID fields each cycle, hold freezes everything.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5
);
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall_id;
    logic                  ex_valid;
    stage_slot_t           ex_slot;
    stage_slot_t           mem_slot;
    stage_slot_t           wb_slot;
    stage_slot_t           wb1_slot;

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread,
        input  fwd_a_sel, fwd_b_sel, stall_id, ex_valid,
        input  ex_slot, mem_slot, wb_slot, wb1_slot
    );

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread,
        output fwd_a_sel, fwd_b_sel, stall_id, ex_valid,
        output ex_slot, mem_slot, wb_slot, wb1_slot
    );
endinterface

// File: rtl/fwd_hazard_unit_sel_calc.sv
// Combinational select for one EX operand, evaluated on the slots as they stand before the edge.
// Each slot advances one stage at the edge, so EX->01, MEM->10, WB->11.
module fwd_sel_calc
    import fwd_pkg::*;
#(
    parameter bit ENABLE_WB1_FWD = 1'b1
) (
    input  logic [SLOT_ADDR_W-1:0] src,
    input  stage_slot_t            ex_slot,
    input  stage_slot_t            mem_slot,
    input  stage_slot_t            wb_slot,
    output logic [1:0]             sel
);
    logic unused_memread;
    assign unused_memread = &{1'b0, ex_slot.memread, mem_slot.memread, wb_slot.memread};

    always_comb begin
        sel = FWD_RF;
        if (is_producer(ex_slot.valid, ex_slot.regwrite, ex_slot.rd, src))
            sel = FWD_EXMEM;
        else if (is_producer(mem_slot.valid, mem_slot.regwrite, mem_slot.rd, src))
            sel = FWD_MEMWB;
        else if (ENABLE_WB1_FWD && is_producer(wb_slot.valid, wb_slot.regwrite, wb_slot.rd, src))
            sel = FWD_WB1;
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks destinations through EX/MEM/WB/WB1, registers operand selects for EX,
// and raises the combinational load-use stall at ID.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter bit ENABLE_WB1_FWD = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fwd_hazard_unit_if.slave       bus
);
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    stage_slot_t           ex_q, mem_q, wb_q, wb1_q;
    stage_slot_t           id_slot;
    logic [1:0]            a_sel_q, b_sel_q;
    logic [1:0]            a_calc, b_calc;
    logic                  load_use;
    logic                  stall;
    logic                  bubble;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.id_rd;

    assign id_slot = '{valid: 1'b1, rd: rd, regwrite: bus.id_regwrite, memread: bus.id_memread};

    assign load_use = ex_q.memread &&
                      (is_producer(ex_q.valid, ex_q.regwrite, ex_q.rd, rs1) ||
                       is_producer(ex_q.valid, ex_q.regwrite, ex_q.rd, rs2));
    // A flushed ID instruction is dead anyway, so it must not stall the front end.
    assign stall  = bus.id_valid && !bus.flush && load_use;
    assign bubble = stall || bus.flush || !bus.id_valid;

    fwd_sel_calc #(.ENABLE_WB1_FWD(ENABLE_WB1_FWD)) u_calc_a (
        .src(rs1), .ex_slot(ex_q), .mem_slot(mem_q), .wb_slot(wb_q), .sel(a_calc)
    );

    fwd_sel_calc #(.ENABLE_WB1_FWD(ENABLE_WB1_FWD)) u_calc_b (
        .src(rs2), .ex_slot(ex_q), .mem_slot(mem_q), .wb_slot(wb_q), .sel(b_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            wb1_q   <= '0;
            a_sel_q <= FWD_RF;
            b_sel_q <= FWD_RF;
        end else if (!bus.hold) begin
            wb1_q   <= wb_q;
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= bubble ? '0 : id_slot;
            a_sel_q <= bubble ? FWD_RF : a_calc;
            b_sel_q <= bubble ? FWD_RF : b_calc;
        end
    end

    assign bus.fwd_a_sel = a_sel_q;
    assign bus.fwd_b_sel = b_sel_q;
    assign bus.stall_id  = stall;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_slot   = ex_q;
    assign bus.mem_slot  = mem_q;
    assign bus.wb_slot   = wb_q;
    assign bus.wb1_slot  = wb1_q;
endmodule
